inst_prefetch_buf: RTL and testbench

Instruction-fetch front end between the 5-bit instruction memory and the CPU decode stage. Walks a fetch PC and reads the combinational instruction memory every cycle. Buffers {pc, instruction} pairs in a small FIFO and presents them to decode with a valid/ready handshake. Decode-side jumps flush the buffer and redirect fetch.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/sync_fifo.sv | 39 +++
 rtl/inst_prefetch_buf.sv | 55 +++++
 tb/tb_inst_prefetch_buf.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-memory geometry, opcodes and fetch entry layout
package cpu_pkg;
  localparam int IM_AW = 5;
  localparam int IM_DW = 8;
  localparam logic [IM_AW-1:0] RESET_PC = 5'd0;
  localparam logic [IM_DW-1:0] OP_HALT = 8'h1F;
  localparam logic [IM_DW-1:0] OP_NOP = 8'h00;
  typedef struct packed {
    logic [IM_AW-1:0] pc;
    logic [IM_DW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x W FIFO with push/pop/flush, occupancy count, async active-high reset; rdata is the head entry or 0 when empty
module sync_fifo #(
  parameter int W = 13,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [PW:0]  count
);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != FULL || do_pop);
  assign rdata = count != '0 ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/inst_prefetch_buf.sv
// inst_prefetch_buf: fetch PC walker feeding a {pc,instr} FIFO to decode with valid/ready, redirect flush, optional HALT stop (INST_PREFETCH_HALT_DETECT_EN); ports: clk, reset, im_abus/im_dbus, fetch_valid/data/pc/ready, redirect/redirect_pc, fetch_stopped
module inst_prefetch_buf
  import cpu_pkg::*;
#(
  parameter int AW = IM_AW,
  parameter int DW = IM_DW,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] im_abus,
  input  logic [DW-1:0] im_dbus,
  output logic          fetch_valid,
  output logic [DW-1:0] fetch_data,
  output logic [AW-1:0] fetch_pc,
  input  logic          fetch_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          fetch_stopped
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [AW-1:0] pc_q;
  logic [PW:0] count;
  logic [AW+DW-1:0] head;
  logic stopped, push, pop;
  assign im_abus = pc_q;
  assign fetch_valid = count != '0 && !redirect;
  assign pop = fetch_valid && fetch_ready;
  assign push = !redirect && !stopped && (count != FULL || pop);
  assign {fetch_pc, fetch_data} = head;
  assign fetch_stopped = stopped;
  sync_fifo #(.W(AW+DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .wdata({pc_q, im_dbus}),
    .rdata(head),
    .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= AW'(RESET_PC);
    else if (redirect) pc_q <= redirect_pc;
    else if (push) pc_q <= pc_q + 1'b1;
`ifdef INST_PREFETCH_HALT_DETECT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) stopped <= 1'b0;
    else if (redirect) stopped <= 1'b0;
    else if (push && im_dbus == DW'(OP_HALT)) stopped <= 1'b1;
`else
  assign stopped = 1'b0;
`endif
endmodule

// File: tb/tb_inst_prefetch_buf.sv
// tb_inst_prefetch_buf: randomized and directed checks of inst_prefetch_buf against a queue-based fetch model
module tb_inst_prefetch_buf;
  localparam int AW = 5, DW = 8, DEPTH = 4;
  logic clk = 0, reset = 1;
  logic [AW-1:0] im_abus, fetch_pc, redirect_pc = 0;
  logic [DW-1:0] im_dbus, fetch_data;
  logic fetch_valid, fetch_ready = 0, redirect = 0, fetch_stopped;
  logic [DW-1:0] imem [32];
  logic [AW+DW-1:0] mq [$];
  logic [AW-1:0] mpc;
  logic mstop;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign im_dbus = imem[im_abus];
  inst_prefetch_buf #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .im_abus(im_abus), .im_dbus(im_dbus),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_stopped(fetch_stopped)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    mpc = 0;
    mstop = 0;
  endtask
  task automatic compare();
    logic [AW+DW-1:0] h;
    h = mq.size() != 0 ? mq[0] : '0;
    chk("fetch_valid", fetch_valid, int'(mq.size() != 0 && !redirect));
    chk("fetch_pc", fetch_pc, h[AW+DW-1:DW]);
    chk("fetch_data", fetch_data, h[DW-1:0]);
    chk("im_abus", im_abus, mpc);
    chk("fetch_stopped", fetch_stopped, mstop);
  endtask
  task automatic model_step(input logic rdy, input logic rd, input logic [AW-1:0] rpc);
    logic p, w;
    if (rd) begin
      mq.delete();
      mpc = rpc;
      mstop = 0;
    end else begin
      p = mq.size() != 0 && rdy;
      w = !mstop && (mq.size() < DEPTH || p);
      if (p) void'(mq.pop_front());
      if (w) begin
        mq.push_back({mpc, imem[mpc]});
`ifdef INST_PREFETCH_HALT_DETECT_EN
        if (imem[mpc] == 8'h1F) mstop = 1;
`endif
        mpc = mpc + 1'b1;
      end
    end
  endtask
  task automatic cycle(input logic rdy, input logic rd, input logic [AW-1:0] rpc);
    fetch_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    #1 compare();
    @(posedge clk);
    model_step(rdy, rd, rpc);
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      do v = 8'($urandom_range(0, 255)); while (v == 8'h1F);
      imem[i] = v;
    end
    imem[9] = 8'h02;
    imem[13] = 8'h1F;
    model_reset();
    #12;
    chk("rst_valid", fetch_valid, 0);
    chk("rst_abus", im_abus, 0);
    chk("rst_pc", fetch_pc, 0);
    chk("rst_data", fetch_data, 0);
    chk("rst_stopped", fetch_stopped, 0);
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    chk("full_abus", im_abus, 4);
    chk("full_valid", fetch_valid, 1);
    chk("full_pc", fetch_pc, 0);
    chk("full_data", fetch_data, imem[0]);
    cycle(1, 0, 0);
    chk("drain_pc", fetch_pc, 1);
    chk("drain_abus", im_abus, 5);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 9);
    redirect = 0;
    #1;
    chk("redir_valid", fetch_valid, 0);
    chk("redir_abus", im_abus, 9);
    cycle(1, 0, 0);
    chk("redir_valid2", fetch_valid, 1);
    chk("redir_pc", fetch_pc, 9);
    chk("redir_data", fetch_data, 8'h02);
    cycle(1, 1, 30);
    cycle(1, 0, 0);
    chk("wrap_pc30", fetch_pc, 30);
    chk("wrap_abus31", im_abus, 31);
    cycle(1, 0, 0);
    chk("wrap_pc31", fetch_pc, 31);
    chk("wrap_abus0", im_abus, 0);
    cycle(1, 0, 0);
    chk("wrap_pc0", fetch_pc, 0);
    cycle(1, 1, 10);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);
`ifdef INST_PREFETCH_HALT_DETECT_EN
    chk("halt_stopped", fetch_stopped, 1);
    chk("halt_abus", im_abus, 14);
    chk("halt_valid", fetch_valid, 0);
`else
    chk("halt_stopped", fetch_stopped, 0);
    chk("halt_abus", im_abus, 18);
`endif
    cycle(1, 1, 0);
    redirect = 0;
    #1 chk("halt_clear", fetch_stopped, 0);
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, AW'($urandom_range(0, 31)));
    cycle(0, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    fetch_ready = 1;
    #2 reset = 1;
    #1;
    chk("arst_valid", fetch_valid, 0);
    chk("arst_abus", im_abus, 0);
    chk("arst_pc", fetch_pc, 0);
    chk("arst_data", fetch_data, 0);
    chk("arst_stopped", fetch_stopped, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) cycle(1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
